// File: rtl/spi_master_if.sv
// Parallel request/response bus between on-chip control logic and spi_master.
// The master modport is the requester; the slave modport is spi_master itself.
interface spi_master_if;
  logic       start;
  logic [1:0] cmd;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       rdata_valid;

  modport master (
    output start, cmd, wdata,
    input  busy, done, rdata, rdata_valid
  );

  modport slave (
    input  start, cmd, wdata,
    output busy, done, rdata, rdata_valid
  );
endinterface

// File: rtl/spi_master.sv
// SPI master for the slave-with-RAM subsystem: sends a select bit plus a 10-bit
// {cmd, data} frame MSB first, and for read-data commands captures an 8-bit reply.
module spi_master #(
  parameter int TURN_CYCLES = 1,
  parameter int GAP_CYCLES  = 2
) (
  input  logic         clk,
  input  logic         rst,
  spi_master_if.slave  req,
  output logic         ss_n,
  output logic         mosi,
  input  logic         miso
);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    SHIFT,
    TURN,
    RECV,
    GAP
  } state_t;

  localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);
  localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES - 1);
  localparam logic [3:0] SHIFT_LOAD = 4'd9;
  localparam logic [3:0] RECV_LOAD  = 4'd7;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  shreg_q, shreg_d;
  logic [7:0]  rx_q, rx_d;
  logic        is_read_q, is_read_d;
  logic        ss_n_q, ss_n_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic        accept;

  // A new request is taken in IDLE or on the final gap cycle, so held starts run back-to-back.
  assign accept = req.start &&
                  ((state_q == IDLE) || ((state_q == GAP) && (cnt_q == 4'd0)));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shreg_d       = shreg_q;
    rx_d          = rx_q;
    is_read_d     = is_read_q;
    ss_n_d        = 1'b1;
    mosi_d        = 1'b0;
    busy_d        = busy_q;
    done_d        = 1'b0;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
      end

      SELECT: begin
        state_d = SHIFT;
        cnt_d   = SHIFT_LOAD;
        ss_n_d  = 1'b0;
        mosi_d  = shreg_q[9];
        shreg_d = {shreg_q[8:0], 1'b0};
      end

      // mosi is registered, so each cycle queues the next bit from the shifted frame.
      SHIFT: begin
        if (cnt_q != 4'd0) begin
          cnt_d   = cnt_q - 4'd1;
          ss_n_d  = 1'b0;
          mosi_d  = shreg_q[9];
          shreg_d = {shreg_q[8:0], 1'b0};
        end else if (is_read_q) begin
          ss_n_d = 1'b0;
          if (TURN_CYCLES > 0) begin
            state_d = TURN;
            cnt_d   = TURN_LOAD;
          end else begin
            state_d = RECV;
            cnt_d   = RECV_LOAD;
          end
        end else begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
          done_d  = 1'b1;
        end
      end

      TURN: begin
        ss_n_d = 1'b0;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RECV;
          cnt_d   = RECV_LOAD;
        end
      end

      RECV: begin
        rx_d = {rx_q[6:0], miso};
        if (cnt_q != 4'd0) begin
          cnt_d  = cnt_q - 4'd1;
          ss_n_d = 1'b0;
        end else begin
          state_d       = GAP;
          cnt_d         = GAP_LOAD;
          rdata_d       = {rx_q[6:0], miso};
          rdata_valid_d = 1'b1;
          done_d        = 1'b1;
        end
      end

      GAP: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (accept) begin
      state_d   = SELECT;
      cnt_d     = 4'd0;
      shreg_d   = {req.cmd, (req.cmd == 2'b11) ? 8'h00 : req.wdata};
      is_read_d = (req.cmd == 2'b11);
      ss_n_d    = 1'b0;
      mosi_d    = req.cmd[1];
      busy_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      shreg_q       <= 10'd0;
      rx_q          <= 8'h00;
      is_read_q     <= 1'b0;
      ss_n_q        <= 1'b1;
      mosi_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rdata_q       <= 8'h00;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shreg_q       <= shreg_d;
      rx_q          <= rx_d;
      is_read_q     <= is_read_d;
      ss_n_q        <= ss_n_d;
      mosi_q        <= mosi_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  assign ss_n            = ss_n_q;
  assign mosi            = mosi_q;
  assign req.busy        = busy_q;
  assign req.done        = done_q;
  assign req.rdata       = rdata_q;
  assign req.rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: table of single frames checked against hand-computed bit
// patterns and timings, driven into a small slave+RAM model, plus corner sequences.
module tb_spi_master;

  logic clk = 1'b0;
  logic rst;
  logic ss_n;
  logic mosi;
  logic miso;

  spi_master_if bus();

  spi_master #(.TURN_CYCLES(1), .GAP_CYCLES(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (bus),
    .ss_n (ss_n),
    .mosi (mosi),
    .miso (miso)
  );

  always #5 clk = ~clk;

  // Slave+RAM model: decodes the select bit and 10-bit frame, answers read-data on miso.
  int          k = 0;
  logic [10:0] frame_bits = '0;
  logic [7:0]  model_addr = '0;
  logic [7:0]  reply = '0;
  logic [7:0]  ram [256];
  logic        loaded = 1'b0;
  logic [10:0] full_frame;

  assign full_frame = {frame_bits[9:0], mosi};

  always @(negedge clk) begin
    if (!loaded) begin
      ram[8'h2B] <= 8'h5A;
      loaded     <= 1'b1;
    end
    if (ss_n) begin
      k    <= 0;
      miso <= 1'b0;
    end else begin
      k <= k + 1;
      if (k <= 10) frame_bits <= full_frame;
      if (k == 10) begin
        case (full_frame[9:8])
          2'b00, 2'b10: model_addr <= full_frame[7:0];
          2'b01:        ram[model_addr] <= full_frame[7:0];
          default:      reply <= ram[model_addr];
        endcase
      end
      if (k >= 12 && k <= 19) miso <= reply[19 - k];
      else                    miso <= 1'b0;
    end
  end

  typedef struct {
    logic [1:0]  cmd;
    logic [7:0]  wdata;
    logic [10:0] exp_bits;
    int          exp_ss_low;
    int          exp_done_cycle;
    int          exp_rv_cycle;
    int          exp_busy;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs [8];

  int checks = 0;
  int errors = 0;

  logic [10:0] obs_bits;
  int          obs_ss_low;
  int          obs_done_cycle;
  int          obs_done_cnt;
  int          obs_rv_cycle;
  int          obs_busy;
  logic [7:0]  obs_rdata;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Runs one frame: start sampled at the edge ending cycle 0, then 28 cycles observed.
  task automatic applyStimulus(input logic [1:0] c, input logic [7:0] d, input int inject_cycle);
    obs_bits       = '0;
    obs_ss_low     = 0;
    obs_done_cycle = 0;
    obs_done_cnt   = 0;
    obs_rv_cycle   = 0;
    obs_busy       = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.cmd   = c;
    bus.wdata = d;
    for (int cyc = 1; cyc <= 28; cyc++) begin
      @(negedge clk);
      if (cyc == 1) bus.start = 1'b0;
      if (!ss_n) begin
        if (obs_ss_low < 11) obs_bits = {obs_bits[9:0], mosi};
        obs_ss_low++;
      end
      if (bus.done) begin
        obs_done_cnt++;
        if (obs_done_cycle == 0) obs_done_cycle = cyc;
      end
      if (bus.rdata_valid && obs_rv_cycle == 0) obs_rv_cycle = cyc;
      if (bus.busy) obs_busy++;
      if (cyc == inject_cycle) begin
        bus.start = 1'b1;
        bus.cmd   = 2'b01;
        bus.wdata = 8'hFF;
      end
      if (cyc == inject_cycle + 1) bus.start = 1'b0;
    end
    obs_rdata = bus.rdata;
  endtask

  task automatic checkFrame(input string tag, input vec_t v);
    checkOutput({tag, "_bits"},   int'(obs_bits),   int'(v.exp_bits));
    checkOutput({tag, "_ss_low"}, obs_ss_low,       v.exp_ss_low);
    checkOutput({tag, "_done_at"}, obs_done_cycle,  v.exp_done_cycle);
    checkOutput({tag, "_done_n"}, obs_done_cnt,     1);
    checkOutput({tag, "_rv_at"},  obs_rv_cycle,     v.exp_rv_cycle);
    checkOutput({tag, "_busy"},   obs_busy,         v.exp_busy);
    checkOutput({tag, "_rdata"},  int'(obs_rdata),  int'(v.exp_rdata));
  endtask

  initial begin
    vec_t v;
    int   falls;
    int   high_run;
    logic seen_low;
    logic prev_ss;

    vecs[0] = '{2'b00, 8'hAB, 11'b0_00_10101011, 11, 12,  0, 13, 8'h00};
    vecs[1] = '{2'b01, 8'hAA, 11'b0_01_10101010, 11, 12,  0, 13, 8'h00};
    vecs[2] = '{2'b10, 8'h2B, 11'b1_10_00101011, 11, 12,  0, 13, 8'h00};
    vecs[3] = '{2'b11, 8'hFF, 11'b1_11_00000000, 20, 21, 21, 22, 8'h5A};
    vecs[4] = '{2'b00, 8'h3D, 11'b0_00_00111101, 11, 12,  0, 13, 8'h5A};
    vecs[5] = '{2'b01, 8'hC3, 11'b0_01_11000011, 11, 12,  0, 13, 8'h5A};
    vecs[6] = '{2'b10, 8'h3D, 11'b1_10_00111101, 11, 12,  0, 13, 8'h5A};
    vecs[7] = '{2'b11, 8'h00, 11'b1_11_00000000, 20, 21, 21, 22, 8'hC3};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.cmd   = 2'b00;
    bus.wdata = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("rst_ss_n",  int'(ss_n),            1);
    checkOutput("rst_mosi",  int'(mosi),            0);
    checkOutput("rst_busy",  int'(bus.busy),        0);
    checkOutput("rst_done",  int'(bus.done),        0);
    checkOutput("rst_rdata", int'(bus.rdata),       0);
    checkOutput("rst_rv",    int'(bus.rdata_valid), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].cmd, vecs[i].wdata, 0);
      checkFrame($sformatf("vec%0d", i), vecs[i]);
      if (i == 1) checkOutput("ram_AB", int'(ram[8'hAB]), 8'hAA);
    end

    // Start pulsed mid-frame must not disturb the running frame or queue another.
    applyStimulus(2'b00, 8'h5C, 5);
    v = '{2'b00, 8'h5C, 11'b0_00_01011100, 11, 12, 0, 13, 8'hC3};
    checkFrame("busy_start", v);

    // Reset during SHIFT bit 4, while mosi is driving a 1.
    @(negedge clk);
    bus.start = 1'b1;
    bus.cmd   = 2'b00;
    bus.wdata = 8'h96;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      if (cyc == 1) bus.start = 1'b0;
    end
    checkOutput("pre_rst_mosi", int'(mosi), 1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_ss_n",  int'(ss_n),      1);
    checkOutput("midrst_busy",  int'(bus.busy),  0);
    checkOutput("midrst_mosi",  int'(mosi),      0);
    checkOutput("midrst_done",  int'(bus.done),  0);
    checkOutput("midrst_rdata", int'(bus.rdata), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(2'b00, 8'h96, 0);
    v = '{2'b00, 8'h96, 11'b0_00_10010110, 11, 12, 0, 13, 8'h00};
    checkFrame("post_rst", v);

    // Held start: frames every 13 cycles with exactly two ss_n-high cycles between them.
    falls    = 0;
    high_run = 0;
    seen_low = 1'b0;
    prev_ss  = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.cmd   = 2'b00;
    bus.wdata = 8'h11;
    for (int cyc = 1; cyc <= 39; cyc++) begin
      @(negedge clk);
      if (!ss_n && prev_ss) begin
        falls++;
        if (seen_low) checkOutput($sformatf("b2b_gap%0d", falls), high_run, 2);
        high_run = 0;
        seen_low = 1'b1;
      end
      if (ss_n && seen_low) high_run++;
      prev_ss = ss_n;
      if (cyc == 39) bus.start = 1'b0;
    end
    checkOutput("b2b_frames", falls, 3);
    repeat (10) @(negedge clk);
    checkOutput("b2b_end_busy", int'(bus.busy), 0);
    checkOutput("b2b_end_ss_n", int'(ss_n),     1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
